// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for the yIF/yID/yEX/yDM/yWB MIPS datapath.
//   Fetches, decodes and sequences one instruction at a time over 3-5
//   states. Drives the register-file, ALU, data-memory and PC-select
//   controls, and counts retired instructions.
//
//   Optional build macro: MULTICYCLE_CTRL_TRAP_EN
//     defined   : an unsupported instruction parks the FSM in TRAP (trap = 1)
//     undefined : an unsupported instruction retires as a 3-cycle NOP and
//                 trap is tied low
//
// Parameters
//   MAX_INSTR   retire count at which the FSM halts (0 = run forever)
//   CNT_W       width of instr_count
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       leave IDLE and begin fetching
//   ins         instruction-memory output, latched at the end of FETCH
//   zero        ALU zero flag (selects the beq branch target)
//   mem_rdy     data memory completes the access this cycle
//   IRWrite     latch the instruction register
//   PCWrite     update the PC (one cycle per instruction = retire)
//   PCsel       00 PC+4, 01 PC+4+(imm<<2), 10 jTarget<<2
//   RegDst      1 = rd, 0 = rt
//   RegWrite    register-file write enable
//   ALUSrc      1 = imm, 0 = rd2
//   MemRead     data-memory read enable
//   MemWrite    data-memory write enable
//   Mem2Reg     1 = write back memOut, 0 = write back z
//   op          ALU op: and 000, or 001, add 010, sub 110, slt 111
//   state       current state, for debug
//   instr_count retired instruction count (wraps)
//   done        halted after MAX_INSTR retires
//   trap        illegal-instruction trap
//
//   state  | meaning
//   -------+------------------------------------------------
//   IDLE 0 | waiting for start, all controls low
//   FETCH 1| IRWrite, latch opcode/funct
//   DECODE2| ALU/mux controls for the latched instruction
//   EXEC 3 | branch/jump/NOP retire here, others move on
//   MEM 4  | lw/sw access, held until mem_rdy
//   WB 5   | register write-back and retire
//   HALT 6 | MAX_INSTR reached, done = 1 until reset
//   TRAP 7 | unsupported instruction, trap = 1 until reset
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MAX_INSTR = 43,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCsel,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic [2:0]       op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             done,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_P4  = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTR);

    state_t           state_q, state_d;
    logic [5:0]       opc_q, opc_d;
    logic [5:0]       funct_q, funct_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             halt_hit;

    logic             is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal;
    logic             dec_regdst, dec_alusrc;
    logic [2:0]       dec_op;

    // Only opcode and funct are latched; the register fields go straight
    // from the IR to the datapath.
    logic             unused_ins;
    assign unused_ins = ^ins[25:6];

    // Instruction class and static ALU/mux controls from the latched fields.
    always_comb begin
        is_r       = 1'b0;
        is_addi    = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        dec_regdst = 1'b0;
        dec_alusrc = 1'b0;
        dec_op     = ALU_AND;
        case (opc_q)
            OPC_RTYPE: begin
                case (funct_q)
                    6'h20:   begin is_r = 1'b1; dec_op = ALU_ADD; end
                    6'h22:   begin is_r = 1'b1; dec_op = ALU_SUB; end
                    6'h24:   begin is_r = 1'b1; dec_op = ALU_AND; end
                    6'h25:   begin is_r = 1'b1; dec_op = ALU_OR;  end
                    6'h2a:   begin is_r = 1'b1; dec_op = ALU_SLT; end
                    default: ;
                endcase
                dec_regdst = is_r;
            end
            OPC_ADDI: begin is_addi = 1'b1; dec_alusrc = 1'b1; dec_op = ALU_ADD; end
            OPC_LW:   begin is_lw   = 1'b1; dec_alusrc = 1'b1; dec_op = ALU_ADD; end
            OPC_SW:   begin is_sw   = 1'b1; dec_alusrc = 1'b1; dec_op = ALU_ADD; end
            OPC_BEQ:  begin is_beq  = 1'b1; dec_alusrc = 1'b0; dec_op = ALU_SUB; end
            OPC_J:    begin is_j    = 1'b1; dec_alusrc = 1'b1; dec_op = ALU_ADD; end
            default:  ;
        endcase
        legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            opc_q   <= 6'h00;
            funct_q <= 6'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign halt_hit = (MAX_INSTR != 0) && (cnt_inc == MAX_CNT);

    // Next-state logic. PCWrite marks the retire cycle of every instruction,
    // so the counter and the HALT decision both key off it.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        funct_d = funct_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                opc_d   = ins[31:26];
                funct_d = ins[5:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                state_d = legal ? S_EXEC : S_TRAP;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (is_lw || is_sw)        state_d = S_MEM;
                else if (is_r || is_addi)  state_d = S_WB;
                else                       state_d = S_FETCH;
            end
            S_MEM: begin
                if (mem_rdy) state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: ;
        endcase
        if (PCWrite) begin
            cnt_d = cnt_inc;
            if (halt_hit) state_d = S_HALT;
        end
    end

    // Output logic: state plus latched instruction; zero and mem_rdy only
    // select the branch target and the sw completion cycle.
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCsel    = PC_P4;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Mem2Reg  = 1'b0;
        op       = ALU_AND;
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            RegDst = dec_regdst;
            ALUSrc = dec_alusrc;
            op     = dec_op;
        end
        case (state_q)
            S_FETCH: IRWrite = 1'b1;
            S_EXEC: begin
                if (is_beq) begin
                    PCWrite = 1'b1;
                    PCsel   = zero ? PC_BR : PC_P4;
                end else if (is_j) begin
                    PCWrite = 1'b1;
                    PCsel   = PC_JMP;
                end else if (!legal) begin
                    PCWrite = 1'b1;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    MemRead = 1'b1;
                end else if (is_sw) begin
                    MemWrite = 1'b1;
                    PCWrite  = mem_rdy;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                Mem2Reg  = is_lw;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
    assign done        = (state_q == S_HALT);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap        = (state_q == S_TRAP);
`else
    assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    localparam int MAX_I = 3;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset, start, zero, mem_rdy;
    logic [31:0]      ins;
    logic             IRWrite, PCWrite, RegDst, RegWrite, ALUSrc;
    logic             MemRead, MemWrite, Mem2Reg, done, trap;
    logic [1:0]       PCsel;
    logic [2:0]       op, state;
    logic [CNT_W-1:0] instr_count;

    int vectors   = 0;
    int errors    = 0;
    int exp_count = 0;

    multicycle_ctrl #(.MAX_INSTR(MAX_I), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .ins(ins), .zero(zero),
        .mem_rdy(mem_rdy), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsel(PCsel),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .op(op), .state(state),
        .instr_count(instr_count), .done(done), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fn_tab  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        logic [5:0]  bad_opc [4] = '{6'h3f, 6'h01, 6'h0d, 6'h2a};
        logic [25:0] body = 26'($urandom);
        int k;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        k = int'($urandom_range(5, 0));
`else
        k = int'($urandom_range(7, 0));
`endif
        case (k)
            0: return {6'h00, body[25:6], fn_tab[$urandom_range(4, 0)]};
            1: return {6'h08, body};
            2: return {6'h23, body};
            3: return {6'h2b, body};
            4: return {6'h04, body};
            5: return {6'h02, body};
            6: return {bad_opc[$urandom_range(3, 0)], body};
            default: return {6'h00, body[25:6], 6'h00};
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from FETCH to its retire cycle and checks it
    // against the architectural expectations for its class.
    task automatic run_instr(input logic [31:0] iw, input logic z, input int waits);
        int         exp_seq[$];
        int         act_seq[$];
        int         exp_rw = 0, exp_mr = 0, exp_mw = 0;
        logic [1:0] exp_pcsel = 2'b00;
        logic [2:0] exp_op = 3'b010;
        logic       exp_rd = 1'b0, exp_as = 1'b0, exp_m2r = 1'b0;
        bit         legal = 1'b1, chk_op = 1'b1, retired = 1'b0, ref_set = 1'b0, seq_bad;
        int         n_ir = 0, n_rw = 0, n_mr = 0, n_mw = 0, n_unstable = 0, cyc = 0, left;
        logic [1:0] pcsel_s = 2'b11;
        logic [2:0] op_s = 3'b000;
        logic       rd_s = 1'b0, as_s = 1'b0, m2r_s = 1'b0;
        logic [4:0] ctl_ref = 5'b0;
        logic [2:0] exp_state;
        logic [5:0] opc, fn;

        opc = iw[31:26];
        fn  = iw[5:0];
        exp_seq = '{1, 2, 3};
        case (opc)
            6'h00: begin
                case (fn)
                    6'h20: exp_op = 3'b010;
                    6'h22: exp_op = 3'b110;
                    6'h24: exp_op = 3'b000;
                    6'h25: exp_op = 3'b001;
                    6'h2a: exp_op = 3'b111;
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    exp_rd = 1'b1;
                    exp_rw = 1;
                    exp_seq.push_back(5);
                end
            end
            6'h08: begin exp_as = 1'b1; exp_rw = 1; exp_seq.push_back(5); end
            6'h23: begin
                exp_as = 1'b1; exp_rw = 1; exp_mr = 1 + waits; exp_m2r = 1'b1;
                repeat (1 + waits) exp_seq.push_back(4);
                exp_seq.push_back(5);
            end
            6'h2b: begin
                exp_as = 1'b1; exp_mw = 1 + waits;
                repeat (1 + waits) exp_seq.push_back(4);
            end
            6'h04: begin exp_op = 3'b110; exp_pcsel = z ? 2'b01 : 2'b00; end
            6'h02: begin exp_as = 1'b1; chk_op = 1'b0; exp_pcsel = 2'b10; end
            default: legal = 1'b0;
        endcase
        if (!legal) chk_op = 1'b0;

        left = waits;
        ins  = iw;
        zero = z;
        while (!retired && cyc < 40) begin
            if (state == 3'd4) begin
                mem_rdy = (left == 0);
                if (left > 0) left--;
            end else begin
                mem_rdy = 1'($urandom);
            end
            #1;
            cyc++;
            act_seq.push_back(int'(state));
            n_ir += int'(IRWrite);
            n_rw += int'(RegWrite);
            n_mr += int'(MemRead);
            n_mw += int'(MemWrite);
            if (state inside {[3'd2:3'd5]}) begin
                if (!ref_set) begin
                    ctl_ref = {RegDst, ALUSrc, op};
                    ref_set = 1'b1;
                end else if ({RegDst, ALUSrc, op} !== ctl_ref) begin
                    n_unstable++;
                end
            end
            if (RegWrite) m2r_s = Mem2Reg;
            if (PCWrite) begin
                retired = 1'b1;
                pcsel_s = PCsel;
                op_s    = op;
                rd_s    = RegDst;
                as_s    = ALUSrc;
            end
            @(negedge clk);
        end
        #1;
        exp_count++;
        exp_state = (exp_count == MAX_I) ? 3'd6 : 3'd1;

        vectors++;
        if (retired !== 1'b1) begin
            errors++;
            $display("FAIL retire ins=%08h: PCWrite seen=%0b required=1", iw, retired);
        end
        vectors++;
        seq_bad = (act_seq.size() != exp_seq.size());
        if (!seq_bad) foreach (exp_seq[i]) if (act_seq[i] != exp_seq[i]) seq_bad = 1'b1;
        if (seq_bad) begin
            errors++;
            $display("FAIL state_seq ins=%08h: got %p required %p", iw, act_seq, exp_seq);
        end
        vectors++;
        if (n_ir !== 1) begin
            errors++;
            $display("FAIL irwrite_cycles ins=%08h: got %0d required 1", iw, n_ir);
        end
        vectors++;
        if ({n_rw, n_mr, n_mw} !== {exp_rw, exp_mr, exp_mw}) begin
            errors++;
            $display("FAIL strobe_cycles ins=%08h: RegWrite/MemRead/MemWrite got %0d/%0d/%0d required %0d/%0d/%0d",
                     iw, n_rw, n_mr, n_mw, exp_rw, exp_mr, exp_mw);
        end
        vectors++;
        if (pcsel_s !== exp_pcsel) begin
            errors++;
            $display("FAIL pcsel ins=%08h: got %b required %b", iw, pcsel_s, exp_pcsel);
        end
        if (legal) begin
            vectors++;
            if ({rd_s, as_s} !== {exp_rd, exp_as}) begin
                errors++;
                $display("FAIL regdst_alusrc ins=%08h: got %b%b required %b%b", iw, rd_s, as_s, exp_rd, exp_as);
            end
            vectors++;
            if (n_unstable !== 0) begin
                errors++;
                $display("FAIL ctl_stable ins=%08h: %0d changed cycles, required 0", iw, n_unstable);
            end
        end
        if (chk_op) begin
            vectors++;
            if (op_s !== exp_op) begin
                errors++;
                $display("FAIL alu_op ins=%08h: got %b required %b", iw, op_s, exp_op);
            end
        end
        if (exp_rw != 0) begin
            vectors++;
            if (m2r_s !== exp_m2r) begin
                errors++;
                $display("FAIL mem2reg ins=%08h: got %b required %b", iw, m2r_s, exp_m2r);
            end
        end
        vectors++;
        if (instr_count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL instr_count ins=%08h: got %0d required %0d", iw, instr_count, exp_count);
        end
        vectors++;
        if ({state, done} !== {exp_state, (exp_count == MAX_I)}) begin
            errors++;
            $display("FAIL post_state ins=%08h: state/done got %0d/%b required %0d/%b",
                     iw, state, done, exp_state, (exp_count == MAX_I));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; ins = $urandom; zero = 1'b0; mem_rdy = 1'b0;
        repeat ($urandom_range(9, 3)) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({state, instr_count, done, trap} !== {3'd0, {CNT_W{1'b0}}, 2'b00}) begin
                errors++;
                $display("FAIL reset_state: state/count/done/trap got %0d/%0d/%b/%b required 0/0/0/0",
                         state, instr_count, done, trap);
            end
            vectors++;
            if ({IRWrite, PCWrite, PCsel, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op} !== 14'b0) begin
                errors++;
                $display("FAIL reset_controls: got %014b required 0",
                         {IRWrite, PCWrite, PCsel, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op});
            end
        end
        reset = 1'b0; start = 1'b0; exp_count = 0;
        @(negedge clk);
        #1;
        vectors++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: state got %0d required 0", state);
        end
    endtask

    task automatic test_directed();
        do_reset();
        begin_run();
        run_instr(32'h00851020, 1'b0, 0);
        run_instr(32'h8C820004, 1'b0, 2);
        run_instr(32'h1085FFFE, 1'b1, 0);
        do_reset();
        begin_run();
        run_instr(32'h1085FFFE, 1'b0, 0);
        run_instr(32'h08000020, 1'($urandom), 0);
        run_instr(32'h00851022, 1'b0, 0);
    endtask

    task automatic test_halt();
        do_reset();
        begin_run();
        repeat (MAX_I) run_instr(32'hAC820000, 1'b0, int'($urandom_range(2, 0)));
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({state, done, instr_count} !== {3'd6, 1'b1, CNT_W'(MAX_I)}) begin
                errors++;
                $display("FAIL halt_sticky: state/done/count got %0d/%b/%0d required 6/1/%0d",
                         state, done, instr_count, MAX_I);
            end
        end
        start = 1'b0;
        do_reset();
        #1;
        vectors++;
        if ({state, done, instr_count} !== {3'd0, 1'b0, {CNT_W{1'b0}}}) begin
            errors++;
            $display("FAIL halt_reset: state/done/count got %0d/%b/%0d required 0/0/0", state, done, instr_count);
        end
    endtask

    task automatic test_illegal();
`ifdef MULTICYCLE_CTRL_TRAP_EN
        logic [31:0] bad [2] = '{32'hFC000000, 32'h00000000};
        foreach (bad[b]) begin
            int pcw = 0;
            do_reset();
            begin_run();
            run_instr(32'h00851020, 1'b0, 0);
            ins = bad[b];
            start = 1'b1;
            repeat (5) begin
                #1;
                pcw += int'(PCWrite);
                @(negedge clk);
            end
            start = 1'b0;
            #1;
            vectors++;
            if ({state, trap, done, instr_count} !== {3'd7, 1'b1, 1'b0, CNT_W'(1)}) begin
                errors++;
                $display("FAIL trap_state ins=%08h: state/trap/done/count got %0d/%b/%b/%0d required 7/1/0/1",
                         bad[b], state, trap, done, instr_count);
            end
            vectors++;
            if (pcw !== 0) begin
                errors++;
                $display("FAIL trap_pcwrite ins=%08h: got %0d cycles required 0", bad[b], pcw);
            end
        end
`else
        do_reset();
        begin_run();
        run_instr(32'hFC000000, 1'($urandom), 0);
        run_instr(32'h00000000, 1'($urandom), 0);
        vectors++;
        if (trap !== 1'b0) begin
            errors++;
            $display("FAIL trap_tied: got %b required 0", trap);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        do_reset();
        begin_run();
        ins = 32'hAC820000;
        mem_rdy = 1'b0;
        #1;
        while (state != 3'd4 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if ({state, MemWrite} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL mid_mem: state/MemWrite got %0d/%b required 4/1", state, MemWrite);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({state, MemWrite, instr_count} !== {3'd0, 1'b0, {CNT_W{1'b0}}}) begin
            errors++;
            $display("FAIL mid_reset: state/MemWrite/count got %0d/%b/%0d required 0/0/0",
                     state, MemWrite, instr_count);
        end
        reset = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_random();
        repeat (10) begin
            do_reset();
            begin_run();
            repeat (MAX_I) run_instr(rand_instr(), 1'($urandom), int'($urandom_range(3, 0)));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ins = 32'h0; zero = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_halt();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
